// File: rtl/hub_port_arbiter_pkg.sv
// Shared constants for the hub broadcast arbiter.
// Frame geometry, state codes and a one-hot helper.
package hub_port_arbiter_pkg;

  localparam int NUM_PORTS     = 4;
  localparam int MAC_BYTES     = 6;
  localparam int PAYLOAD_BYTES = 70;

  // start bit + dst MAC + src MAC + payload
  localparam int FRAME_BITS_DEF =
    1 + (2 * MAC_BYTES + PAYLOAD_BYTES) * 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic logic [3:0] onehot4(
    input logic [1:0] i
  );
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/hub_port_arbiter_if.sv
// Arbiter-to-port-receiver bundle.
// master = arbiter, slave = port receivers.
interface hub_port_arbiter_if #(
  parameter int CNT_W = 10
);

  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic [3:0]       tx_en;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_start;
  logic             frame_end;

  modport master (
    input  req,
    output gnt,
    output gnt_idx,
    output tx_en,
    output bit_cnt,
    output frame_start,
    output frame_end
  );

  modport slave (
    output req,
    input  gnt,
    input  gnt_idx,
    input  tx_en,
    input  bit_cnt,
    input  frame_start,
    input  frame_end
  );

endinterface

// File: rtl/hub_port_arbiter_rr_select4.sv
// Rotating-priority encoder for four requesters.
// Search starts at last+1 and wraps modulo 4.
module rr_select4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] sel
);

  logic [7:0] dbl;
  logic [2:0] shift;
  logic [3:0] rot;
  logic [1:0] off;

  always_comb begin
    dbl   = {req, req};
    shift = {1'b0, last} + 3'd1;
    // rot[0] is the highest-priority port
    rot   = 4'(dbl >> shift);
    valid = |req;
    off   = 2'd0;
    unique casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    sel = last + 2'd1 + off;
  end

endmodule

// File: rtl/hub_port_arbiter.sv
// Round-robin owner of the hub broadcast path.
// Grants one port per frame, then holds an idle gap.
module hub_port_arbiter
  import hub_port_arbiter_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 10
) (
  input logic clk,
  input logic reset,
  hub_port_arbiter_if.master bus
);

  localparam int GAP_W =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state;
  logic [1:0]       last;
  logic [3:0]       gnt_q;
  logic [1:0]       idx_q;
  logic [3:0]       txen_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fs_q;
  logic             fe_q;
  logic [GAP_W-1:0] gap_q;

  logic       sel_v;
  logic [1:0] sel;

  rr_select4 u_sel (
    .req   (bus.req),
    .last  (last),
    .valid (sel_v),
    .sel   (sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      last   <= 2'd3;
      gnt_q  <= 4'b0;
      idx_q  <= 2'd0;
      txen_q <= 4'b0;
      cnt_q  <= '0;
      fs_q   <= 1'b0;
      fe_q   <= 1'b0;
      gap_q  <= '0;
    end else begin
      fs_q <= 1'b0;
      fe_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (sel_v) begin
            state  <= ST_SEND;
            gnt_q  <= onehot4(sel);
            idx_q  <= sel;
            last   <= sel;
            txen_q <= ~onehot4(sel);
            cnt_q  <= '0;
            fs_q   <= 1'b1;
            fe_q   <= (FRAME_BITS == 1);
          end
        end
        ST_SEND: begin
          // committed frame: req is not looked at here
          if (cnt_q == LAST_BIT) begin
            gnt_q  <= 4'b0;
            idx_q  <= 2'd0;
            txen_q <= 4'b0;
            cnt_q  <= '0;
            gap_q  <= '0;
            state  <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            fe_q  <= (cnt_q + CNT_W'(1)) == LAST_BIT;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_idx     = idx_q;
  assign bus.tx_en       = txen_q;
  assign bus.bit_cnt     = cnt_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_end   = fe_q;

endmodule
